store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Holds executed stores between address/data generation and ROB retirement.
- Consumes the ROB commit port (commit pulse plus ROB index of a retiring STORE) and marks the matching entry committed.
- Drains committed entries in order to the D-cache write port; forwards data to younger loads.
- Drops all uncommitted entries on ROB nuke.

Parameters:
- SB_SIZE, 4, number of entries (power of 2, at least 2).
- ROB_IDX_W, 4, width of ROB index tags.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_store_valid  in  1  store from execute wants an entry
- in_store_rob_idx  in  ROB_IDX_W  ROB slot of that store
- in_store_addr  in  32  byte address
- in_store_data  in  32  store data (byte stores use [7:0])
- in_store_byte  in  1  1=SB (byte), 0=SW (word)
- in_commit  in  1  ROB retires a STORE this cycle
- in_commit_rob_idx  in  ROB_IDX_W  ROB slot being retired
- in_rob_nuke  in  1  ROB flush
- in_drain_ready  in  1  D-cache accepts a write this cycle
- out_drain_valid  out  1  head entry committed, write offered
- out_drain_addr  out  32  head address
- out_drain_data  out  32  head data
- out_drain_byte  out  1  head size
- in_load_valid  in  1  load probing for forwarding
- in_load_addr  in  32  load byte address
- in_load_byte  in  1  1=LB, 0=LW
- out_fwd_hit  out  1  load fully satisfied from buffer
- out_fwd_data  out  32  forwarded value (LB: sign-extended byte)
- out_fwd_stall  out  1  overlapping store cannot supply load; load must wait
- out_full  out  1  count==SB_SIZE
- out_empty  out  1  count==0
- out_count  out  $clog2(SB_SIZE)+1  occupied entries

Behaviour:
- Storage: circular FIFO. Per entry: valid, committed, rob_idx, addr, data, byte. Registers: head, tail, count. Pointers wrap modulo SB_SIZE.
- Reset (reset=0, async):
  - all entries invalid and uncommitted.
  - head=tail=count=0.
  - out_empty=1; every other output 0.
- Allocate: when in_store_valid && !out_full && !in_rob_nuke, write the entry at tail (valid=1, committed=0); tail+1, count+1. Request while full is dropped; execute must stall on out_full.
- Commit:
  - when in_commit, mark committed the valid, uncommitted entry whose rob_idx==in_commit_rob_idx.
  - No match: ignored, no state change.
  - Commits arrive in program order, so committed entries always form a contiguous block from head.
- Drain:
  - out_drain_valid = valid[head] && committed[head]; addr/data/byte combinational from head.
  - Transfer occurs when out_drain_valid && in_drain_ready; the entry is cleared, head+1, count-1.
  - An entry committed in cycle N is offered at the earliest in cycle N+1.
- Simultaneous allocate+drain: count unchanged, both pointers advance. This is legal when full; the full check uses the registered count, so an allocate while full is still rejected.
- Nuke:
  - on in_rob_nuke, every uncommitted entry is invalidated; committed entries stay and continue draining.
  - tail = head + number of committed entries (after applying any same-cycle commit and drain); count updated to match.
  - A same-cycle allocate is dropped; nuke has priority.
- Forwarding (combinational; ignore in_load_* when in_load_valid=0):
  - Scan from youngest (tail-1) to oldest (head), considering valid entries only, committed or not.
  - Overlap: addr[31:2] equal. A byte store with a byte load overlaps only if addr[1:0] equal as well; otherwise the scan continues to older entries.
  - The first overlapping entry decides:
    - word store → hit; LW gets data, LB gets selected byte sign-extended.
    - byte store + LB → hit, sign-extended data[7:0].
    - byte store + LW → out_fwd_stall=1, hit=0.
  - No overlap: hit=0, stall=0, data=0. hit and stall are never both 1.
- Reset mid-drain: offered write vanishes immediately; cache must ignore it.

Test Plan:
- Reset → alloc 3 stores (rob 2,3,4; addr 0x100/0x104/0x108) → count=3; no drain. Commit rob 2 at cycle N → drain_valid at N+1 with addr 0x100; ready=1 → count=2.
- Fill 4 entries → out_full=1. 5th alloc dropped. Same-cycle drain+alloc when full → alloc still dropped, count=3. Next alloc accepted at wrapped tail=0.
- 4 entries, first 2 committed, nuke → count=2, tail=head+2. Both committed stores still drain; same-cycle alloc ignored.
- SW 0x200=0xDEADBEEF then SB 0x201=0x7F. LB 0x201 → hit, 0x0000007F. LB 0x203 → hit, 0xFFFFFFDE. LW 0x200 → stall=1.
- Commit with an unmatched rob_idx=9 → no change. Drain with in_drain_ready=0 for 5 cycles → drain outputs held stable.
- Assert reset low while drain_valid=1 → all outputs 0 in the same cycle, out_empty=1.

Source files
------------

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer: allocate, commit, drain to D-cache, forward to loads
module store_buffer #(
    parameter int SB_SIZE   = 4,
    parameter int ROB_IDX_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_store_valid,
    input  logic [ROB_IDX_W-1:0]     in_store_rob_idx,
    input  logic [31:0]              in_store_addr,
    input  logic [31:0]              in_store_data,
    input  logic                     in_store_byte,
    input  logic                     in_commit,
    input  logic [ROB_IDX_W-1:0]     in_commit_rob_idx,
    input  logic                     in_rob_nuke,
    input  logic                     in_drain_ready,
    output logic                     out_drain_valid,
    output logic [31:0]              out_drain_addr,
    output logic [31:0]              out_drain_data,
    output logic                     out_drain_byte,
    input  logic                     in_load_valid,
    input  logic [31:0]              in_load_addr,
    input  logic                     in_load_byte,
    output logic                     out_fwd_hit,
    output logic [31:0]              out_fwd_data,
    output logic                     out_fwd_stall,
    output logic                     out_full,
    output logic                     out_empty,
    output logic [$clog2(SB_SIZE):0] out_count
);
    localparam int PTR_W = $clog2(SB_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SB_SIZE);

    logic [SB_SIZE-1:0]   ent_valid;
    logic [SB_SIZE-1:0]   ent_committed;
    logic [SB_SIZE-1:0]   ent_byte;
    logic [ROB_IDX_W-1:0] ent_rob  [SB_SIZE];
    logic [31:0]          ent_addr [SB_SIZE];
    logic [31:0]          ent_data [SB_SIZE];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;

    logic                 alloc;
    logic                 drain_fire;
    logic [SB_SIZE-1:0]   valid_nx;
    logic [SB_SIZE-1:0]   committed_nx;
    logic [PTR_W-1:0]     head_nx;
    logic [PTR_W-1:0]     tail_nx;
    logic [CNT_W-1:0]     count_nx;
    logic [CNT_W-1:0]     n_committed;
    logic [PTR_W-1:0]     scan_idx;
    logic [7:0]           sel_byte;

    assign out_count       = count;
    assign out_full        = (count == CNT_FULL);
    assign out_empty       = (count == '0);
    // Payload is not reset, so the drain bus is gated to read zero unless an entry is offered.
    assign out_drain_valid = ent_valid[head] & ent_committed[head];
    assign out_drain_addr  = out_drain_valid ? ent_addr[head] : 32'h0;
    assign out_drain_data  = out_drain_valid ? ent_data[head] : 32'h0;
    assign out_drain_byte  = out_drain_valid & ent_byte[head];

    assign alloc      = in_store_valid & ~out_full & ~in_rob_nuke;
    assign drain_fire = out_drain_valid & in_drain_ready;

    always_comb begin
        valid_nx     = ent_valid;
        committed_nx = ent_committed;
        head_nx      = head;
        tail_nx      = tail;
        count_nx     = count;
        n_committed  = '0;
        for (int i = 0; i < SB_SIZE; i++) begin
            if (in_commit && ent_valid[i] && !ent_committed[i] && ent_rob[i] == in_commit_rob_idx)
                committed_nx[i] = 1'b1;
        end
        if (drain_fire) begin
            valid_nx[head]     = 1'b0;
            committed_nx[head] = 1'b0;
            head_nx            = head + PTR_ONE;
        end
        for (int i = 0; i < SB_SIZE; i++) begin
            if (valid_nx[i] && committed_nx[i])
                n_committed = n_committed + CNT_ONE;
        end
        // Committed entries are contiguous from head, so a nuke just pulls tail back behind them.
        if (in_rob_nuke) begin
            valid_nx = valid_nx & committed_nx;
            tail_nx  = head_nx + n_committed[PTR_W-1:0];
            count_nx = n_committed;
        end else begin
            if (alloc) begin
                valid_nx[tail]     = 1'b1;
                committed_nx[tail] = 1'b0;
                tail_nx            = tail + PTR_ONE;
            end
            case ({alloc, drain_fire})
                2'b10:   count_nx = count + CNT_ONE;
                2'b01:   count_nx = count - CNT_ONE;
                default: count_nx = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_valid     <= '0;
            ent_committed <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
        end else begin
            ent_valid     <= valid_nx;
            ent_committed <= committed_nx;
            head          <= head_nx;
            tail          <= tail_nx;
            count         <= count_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_rob[tail]  <= in_store_rob_idx;
            ent_addr[tail] <= in_store_addr;
            ent_data[tail] <= in_store_data;
            ent_byte[tail] <= in_store_byte;
        end
    end

    // Walk oldest to youngest so the youngest overlapping store has the final say.
    always_comb begin
        out_fwd_hit   = 1'b0;
        out_fwd_stall = 1'b0;
        out_fwd_data  = 32'h0;
        scan_idx      = head;
        sel_byte      = 8'h0;
        for (int k = 0; k < SB_SIZE; k++) begin
            scan_idx = head + PTR_W'(k);
            if (in_load_valid && ent_valid[scan_idx]
                && ent_addr[scan_idx][31:2] == in_load_addr[31:2]
                && !(ent_byte[scan_idx] && in_load_byte
                     && ent_addr[scan_idx][1:0] != in_load_addr[1:0])) begin
                if (!ent_byte[scan_idx]) begin
                    sel_byte      = ent_data[scan_idx][{in_load_addr[1:0], 3'b000} +: 8];
                    out_fwd_hit   = 1'b1;
                    out_fwd_stall = 1'b0;
                    out_fwd_data  = in_load_byte ? {{24{sel_byte[7]}}, sel_byte} : ent_data[scan_idx];
                end else if (in_load_byte) begin
                    sel_byte      = ent_data[scan_idx][7:0];
                    out_fwd_hit   = 1'b1;
                    out_fwd_stall = 1'b0;
                    out_fwd_data  = {{24{sel_byte[7]}}, sel_byte};
                end else begin
                    out_fwd_hit   = 1'b0;
                    out_fwd_stall = 1'b1;
                    out_fwd_data  = 32'h0;
                end
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer against a queue-based model
module tb_store_buffer;
    localparam int SB_SIZE   = 4;
    localparam int ROB_IDX_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_store_valid;
    logic [3:0]  in_store_rob_idx;
    logic [31:0] in_store_addr;
    logic [31:0] in_store_data;
    logic        in_store_byte;
    logic        in_commit;
    logic [3:0]  in_commit_rob_idx;
    logic        in_rob_nuke;
    logic        in_drain_ready;
    logic        out_drain_valid;
    logic [31:0] out_drain_addr;
    logic [31:0] out_drain_data;
    logic        out_drain_byte;
    logic        in_load_valid;
    logic [31:0] in_load_addr;
    logic        in_load_byte;
    logic        out_fwd_hit;
    logic [31:0] out_fwd_data;
    logic        out_fwd_stall;
    logic        out_full;
    logic        out_empty;
    logic [2:0]  out_count;

    always #5 clk = ~clk;

    store_buffer #(.SB_SIZE(SB_SIZE), .ROB_IDX_W(ROB_IDX_W)) dut (
        .clk(clk), .reset(reset),
        .in_store_valid(in_store_valid), .in_store_rob_idx(in_store_rob_idx),
        .in_store_addr(in_store_addr), .in_store_data(in_store_data), .in_store_byte(in_store_byte),
        .in_commit(in_commit), .in_commit_rob_idx(in_commit_rob_idx), .in_rob_nuke(in_rob_nuke),
        .in_drain_ready(in_drain_ready), .out_drain_valid(out_drain_valid),
        .out_drain_addr(out_drain_addr), .out_drain_data(out_drain_data), .out_drain_byte(out_drain_byte),
        .in_load_valid(in_load_valid), .in_load_addr(in_load_addr), .in_load_byte(in_load_byte),
        .out_fwd_hit(out_fwd_hit), .out_fwd_data(out_fwd_data), .out_fwd_stall(out_fwd_stall),
        .out_full(out_full), .out_empty(out_empty), .out_count(out_count)
    );

    typedef struct packed {
        logic [3:0]  rob;
        logic [31:0] addr;
        logic [31:0] data;
        logic        bt;
        logic        cm;
    } ent_t;

    ent_t q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void model_fwd(input logic lv, input logic [31:0] la, input logic lb,
                                      output logic hit, output logic stall, output logic [31:0] d);
        logic [31:0] sh;
        logic [7:0]  b;
        hit = 1'b0; stall = 1'b0; d = 32'h0;
        if (!lv) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].addr[31:2] != la[31:2]) continue;
            if (q[i].bt && lb && q[i].addr[1:0] != la[1:0]) continue;
            if (!q[i].bt) begin
                hit = 1'b1;
                sh  = q[i].data >> (8 * la[1:0]);
                b   = sh[7:0];
                d   = lb ? 32'($signed(b)) : q[i].data;
            end else if (lb) begin
                hit = 1'b1;
                b   = q[i].data[7:0];
                d   = 32'($signed(b));
            end else begin
                stall = 1'b1;
            end
            break;
        end
    endfunction

    function automatic void model_step();
        bit   full  = (q.size() == SB_SIZE);
        bit   drain = (q.size() > 0) && q[0].cm && in_drain_ready;
        ent_t e;
        ent_t keep[$];
        if (in_commit) begin
            for (int i = 0; i < q.size(); i++) begin
                if (!q[i].cm && q[i].rob == in_commit_rob_idx) begin
                    e = q[i]; e.cm = 1'b1; q[i] = e;
                    break;
                end
            end
        end
        if (drain) void'(q.pop_front());
        if (in_rob_nuke) begin
            foreach (q[i]) if (q[i].cm) keep.push_back(q[i]);
            q = keep;
        end else if (in_store_valid && !full) begin
            e.rob = in_store_rob_idx; e.addr = in_store_addr; e.data = in_store_data;
            e.bt = in_store_byte; e.cm = 1'b0;
            q.push_back(e);
        end
    endfunction

    task automatic idle();
        in_store_valid = 0; in_store_rob_idx = 0; in_store_addr = 0; in_store_data = 0; in_store_byte = 0;
        in_commit = 0; in_commit_rob_idx = 0; in_rob_nuke = 0; in_drain_ready = 0;
        in_load_valid = 0; in_load_addr = 0; in_load_byte = 0;
    endtask

    task automatic advance();
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic alloc(input logic [3:0] r, input logic [31:0] a, input logic [31:0] d, input logic b);
        in_store_valid = 1; in_store_rob_idx = r; in_store_addr = a; in_store_data = d; in_store_byte = b;
        advance();
        in_store_valid = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        in_load_valid = 1; in_load_addr = 32'h0;
        #3;
        checks++; if (out_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", out_empty); end
        checks++; if (out_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", out_count); end
        checks++; if ({out_full, out_drain_valid, out_drain_byte, out_fwd_hit, out_fwd_stall} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000", {out_full, out_drain_valid, out_drain_byte, out_fwd_hit, out_fwd_stall}); end
        checks++; if ({out_drain_addr, out_drain_data, out_fwd_data} !== 96'h0) begin
            failures++; $display("FAIL reset_buses got=%h exp=0", {out_drain_addr, out_drain_data, out_fwd_data}); end
        @(posedge clk); #1;
        reset = 1'b1;
        idle();
    endtask

    task automatic test_alloc_commit_drain();
        do_reset();
        alloc(4'd2, 32'h100, 32'h11111111, 0);
        alloc(4'd3, 32'h104, 32'h22222222, 0);
        alloc(4'd4, 32'h108, 32'h33333333, 0);
        #2;
        checks++; if (out_count !== 3'd3) begin failures++; $display("FAIL acd_count3 got=%0d exp=3", out_count); end
        checks++; if (out_drain_valid !== 1'b0) begin failures++; $display("FAIL acd_nodrain got=%b exp=0", out_drain_valid); end
        in_commit = 1; in_commit_rob_idx = 4'd2;
        #1;
        checks++; if (out_drain_valid !== 1'b0) begin failures++; $display("FAIL acd_commit_cycle got=%b exp=0", out_drain_valid); end
        advance();
        in_commit = 0; in_drain_ready = 1;
        #2;
        checks++; if (out_drain_valid !== 1'b1) begin failures++; $display("FAIL acd_drain_valid got=%b exp=1", out_drain_valid); end
        checks++; if (out_drain_addr !== 32'h100) begin failures++; $display("FAIL acd_drain_addr got=%h exp=100", out_drain_addr); end
        checks++; if (out_drain_data !== 32'h11111111) begin failures++; $display("FAIL acd_drain_data got=%h exp=11111111", out_drain_data); end
        advance();
        in_drain_ready = 0;
        #2;
        checks++; if (out_count !== 3'd2) begin failures++; $display("FAIL acd_count2 got=%0d exp=2", out_count); end
        checks++; if (out_drain_valid !== 1'b0) begin failures++; $display("FAIL acd_after got=%b exp=0", out_drain_valid); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) alloc(4'(i), 32'h140 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 0);
        #2;
        checks++; if (out_full !== 1'b1) begin failures++; $display("FAIL fw_full got=%b exp=1", out_full); end
        alloc(4'd4, 32'h180, 32'h5555_5555, 0);
        #2;
        checks++; if (out_count !== 3'd4) begin failures++; $display("FAIL fw_drop5 got=%0d exp=4", out_count); end
        in_commit = 1; in_commit_rob_idx = 4'd0;
        advance();
        in_commit = 0; in_drain_ready = 1;
        in_store_valid = 1; in_store_rob_idx = 4'd5; in_store_addr = 32'h190; in_store_data = 32'h1919_1919;
        #2;
        checks++; if (out_drain_valid !== 1'b1) begin failures++; $display("FAIL fw_drain_offer got=%b exp=1", out_drain_valid); end
        advance();
        in_store_valid = 0; in_drain_ready = 0;
        #2;
        checks++; if (out_count !== 3'd3) begin failures++; $display("FAIL fw_drain_alloc got=%0d exp=3", out_count); end
        alloc(4'd6, 32'h1A0, 32'hCAFE_F00D, 0);
        in_load_valid = 1; in_load_addr = 32'h1A0; in_load_byte = 0;
        #2;
        checks++; if (out_count !== 3'd4) begin failures++; $display("FAIL fw_wrap_count got=%0d exp=4", out_count); end
        checks++; if (out_fwd_hit !== 1'b1 || out_fwd_data !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL fw_wrap_fwd got=%b/%h exp=1/cafef00d", out_fwd_hit, out_fwd_data); end
        in_load_addr = 32'h190;
        #1;
        checks++; if (out_fwd_hit !== 1'b0) begin failures++; $display("FAIL fw_dropped_fwd got=%b exp=0", out_fwd_hit); end
        in_load_valid = 0;
    endtask

    task automatic test_nuke();
        do_reset();
        for (int i = 0; i < 4; i++) alloc(4'(4 + i), 32'h300 + 32'(4 * i), 32'h3000_0000 + 32'(i), 0);
        in_commit = 1; in_commit_rob_idx = 4'd4; advance();
        in_commit_rob_idx = 4'd5; advance();
        in_commit = 0;
        in_rob_nuke = 1; in_store_valid = 1; in_store_rob_idx = 4'd8; in_store_addr = 32'h3F0;
        advance();
        in_rob_nuke = 0; in_store_valid = 0;
        in_load_valid = 1; in_load_addr = 32'h3F0;
        #2;
        checks++; if (out_count !== 3'd2) begin failures++; $display("FAIL nk_count got=%0d exp=2", out_count); end
        checks++; if (out_fwd_hit !== 1'b0) begin failures++; $display("FAIL nk_alloc_dropped got=%b exp=0", out_fwd_hit); end
        in_load_addr = 32'h308;
        #1;
        checks++; if (out_fwd_hit !== 1'b0) begin failures++; $display("FAIL nk_uncommitted_gone got=%b exp=0", out_fwd_hit); end
        in_load_valid = 0; in_drain_ready = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (out_drain_valid !== 1'b1 || out_drain_addr !== 32'h300 + 32'(4 * i)) begin
                failures++; $display("FAIL nk_drain%0d got=%b/%h exp=1/%h", i, out_drain_valid, out_drain_addr, 32'h300 + 32'(4 * i)); end
            advance();
        end
        in_drain_ready = 0;
        #2;
        checks++; if (out_empty !== 1'b1) begin failures++; $display("FAIL nk_empty got=%b exp=1", out_empty); end
        alloc(4'd9, 32'h310, 32'h9999_0310, 0);
        in_commit = 1; in_commit_rob_idx = 4'd9; advance();
        in_commit = 0; in_drain_ready = 1;
        #2;
        checks++; if (out_drain_valid !== 1'b1 || out_drain_data !== 32'h9999_0310) begin
            failures++; $display("FAIL nk_tail_reuse got=%b/%h exp=1/99990310", out_drain_valid, out_drain_data); end
        advance();
        in_drain_ready = 0;
    endtask

    task automatic test_forwarding();
        logic [31:0] la [7]  = '{32'h201, 32'h203, 32'h202, 32'h200, 32'h200, 32'h204, 32'h201};
        logic        lb [7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        lv [7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        eh [7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        es [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ed [7]  = '{32'h7F, 32'hFFFFFFDE, 32'hFFFFFFAD, 32'hFFFFFFEF, 32'h0, 32'h0, 32'h0};
        do_reset();
        alloc(4'd1, 32'h200, 32'hDEADBEEF, 0);
        alloc(4'd2, 32'h201, 32'hAAAAAA7F, 1);
        for (int i = 0; i < 7; i++) begin
            in_load_valid = lv[i]; in_load_addr = la[i]; in_load_byte = lb[i];
            #1;
            checks++; if ({out_fwd_hit, out_fwd_stall, out_fwd_data} !== {eh[i], es[i], ed[i]}) begin
                failures++; $display("FAIL fwd_case%0d got=%b/%b/%h exp=%b/%b/%h", i, out_fwd_hit, out_fwd_stall, out_fwd_data, eh[i], es[i], ed[i]); end
        end
        in_load_valid = 0;
    endtask

    task automatic test_unmatched_and_hold();
        do_reset();
        alloc(4'd1, 32'h600, 32'h6060_6060, 1);
        in_commit = 1; in_commit_rob_idx = 4'd9; advance();
        in_commit = 0;
        #2;
        checks++; if (out_drain_valid !== 1'b0 || out_count !== 3'd1) begin
            failures++; $display("FAIL um_nochange got=%b/%0d exp=0/1", out_drain_valid, out_count); end
        in_commit = 1; in_commit_rob_idx = 4'd1; advance();
        in_commit = 0; in_drain_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++; if ({out_drain_valid, out_drain_addr, out_drain_data, out_drain_byte} !== {1'b1, 32'h600, 32'h6060_6060, 1'b1}) begin
                failures++; $display("FAIL hold_cycle%0d got=%b/%h/%h/%b exp=1/600/60606060/1", i, out_drain_valid, out_drain_addr, out_drain_data, out_drain_byte); end
            advance();
        end
        in_drain_ready = 1; advance();
        in_drain_ready = 0;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        alloc(4'd3, 32'h700, 32'h7777_7777, 0);
        in_commit = 1; in_commit_rob_idx = 4'd3; advance();
        in_commit = 0;
        #2;
        checks++; if (out_drain_valid !== 1'b1) begin failures++; $display("FAIL rmd_offered got=%b exp=1", out_drain_valid); end
        reset = 1'b0;
        #1;
        checks++; if ({out_drain_valid, out_drain_addr, out_drain_data, out_count, out_full} !== 69'h0) begin
            failures++; $display("FAIL rmd_cleared got=%b/%h/%h/%0d/%b exp=0", out_drain_valid, out_drain_addr, out_drain_data, out_count, out_full); end
        checks++; if (out_empty !== 1'b1) begin failures++; $display("FAIL rmd_empty got=%b exp=1", out_empty); end
        q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0]  rob_ctr = 0;
        logic        e_dv, e_hit, e_stall;
        logic [31:0] e_da, e_dd, e_fd;
        logic        e_db;
        int          oldest;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_store_valid   = ($urandom_range(0, 1) == 1);
            in_store_rob_idx = rob_ctr;
            in_store_addr    = 32'h400 + 32'($urandom_range(0, 15));
            in_store_data    = $urandom;
            in_store_byte    = $urandom_range(0, 1);
            in_rob_nuke      = ($urandom_range(0, 19) == 0);
            in_drain_ready   = ($urandom_range(0, 9) < 6);
            in_load_valid    = ($urandom_range(0, 3) != 0);
            in_load_addr     = 32'h400 + 32'($urandom_range(0, 15));
            in_load_byte     = $urandom_range(0, 1);
            oldest = -1;
            foreach (q[i]) if (oldest < 0 && !q[i].cm) oldest = i;
            in_commit = 0;
            if ($urandom_range(0, 9) == 0) begin
                in_commit = 1; in_commit_rob_idx = rob_ctr + 4'd8;
            end else if (oldest >= 0 && $urandom_range(0, 9) < 4) begin
                in_commit = 1; in_commit_rob_idx = q[oldest].rob;
            end
            #2;
            e_dv = (q.size() > 0) && q[0].cm;
            e_da = e_dv ? q[0].addr : 32'h0;
            e_dd = e_dv ? q[0].data : 32'h0;
            e_db = e_dv ? q[0].bt : 1'b0;
            model_fwd(in_load_valid, in_load_addr, in_load_byte, e_hit, e_stall, e_fd);
            checks++; if (out_count !== 3'(q.size()) || out_full !== (q.size() == SB_SIZE) || out_empty !== (q.size() == 0)) begin
                failures++; $display("FAIL rnd_occupancy cyc=%0d got=%0d/%b/%b exp=%0d", c, out_count, out_full, out_empty, q.size()); end
            checks++; if ({out_drain_valid, out_drain_addr, out_drain_data, out_drain_byte} !== {e_dv, e_da, e_dd, e_db}) begin
                failures++; $display("FAIL rnd_drain cyc=%0d got=%b/%h/%h/%b exp=%b/%h/%h/%b", c, out_drain_valid, out_drain_addr, out_drain_data, out_drain_byte, e_dv, e_da, e_dd, e_db); end
            checks++; if ({out_fwd_hit, out_fwd_stall, out_fwd_data} !== {e_hit, e_stall, e_fd}) begin
                failures++; $display("FAIL rnd_fwd cyc=%0d got=%b/%b/%h exp=%b/%b/%h", c, out_fwd_hit, out_fwd_stall, out_fwd_data, e_hit, e_stall, e_fd); end
            if (in_store_valid && !in_rob_nuke && q.size() < SB_SIZE) rob_ctr = rob_ctr + 4'd1;
            advance();
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b0;
        test_reset();
        test_alloc_commit_drain();
        test_full_wrap();
        test_nuke();
        test_forwarding();
        test_unmatched_and_hold();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
